// File: rtl/barrel_shift_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shift_pipe_if
// Brief    : Operation/result handshake bundle for barrel_shift_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
);
    logic             in_Valid;
    logic             out_Ready;
    logic [WIDTH-1:0] in_Val;
    logic [AMT_W-1:0] in_Amt;
    logic [1:0]       in_Shift_type;
    logic             in_Imm_mode;
    logic             in_C_flag;
    logic             out_Valid;
    logic             in_Ready;
    logic [WIDTH-1:0] out_Op2;
    logic             out_Carry;

    modport master (
        output in_Valid, in_Val, in_Amt, in_Shift_type, in_Imm_mode, in_C_flag, in_Ready,
        input  out_Ready, out_Valid, out_Op2, out_Carry
    );

    modport slave (
        input  in_Valid, in_Val, in_Amt, in_Shift_type, in_Imm_mode, in_C_flag, in_Ready,
        output out_Ready, out_Valid, out_Op2, out_Carry
    );
endinterface
`default_nettype wire

// File: rtl/barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shift_pipe
// Brief    : Pipelined LSL/LSR/ASR/ROR shifter with carry-out, valid/ready.
//            Define SHIFTER_PIPE2_EN to register between decode and shift.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_shift_pipe #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
) (
    input  logic               in_Clk,
    input  logic               in_Rst,
    barrel_shift_pipe_if.slave bus
);
    localparam int c_lw = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] c_width_amt = AMT_W'(WIDTH);

    localparam logic [1:0] c_lsl = 2'b00;
    localparam logic [1:0] c_lsr = 2'b01;
    localparam logic [1:0] c_asr = 2'b10;

    // Decoded operation kinds; everything except c_k_shift has a fixed carry.
    localparam logic [2:0] c_k_shift = 3'd0;
    localparam logic [2:0] c_k_pass  = 3'd1;
    localparam logic [2:0] c_k_zero  = 3'd2;
    localparam logic [2:0] c_k_sign  = 3'd3;
    localparam logic [2:0] c_k_rrx   = 3'd4;

    logic [2:0]      w_kind;
    logic [c_lw-1:0] w_s;
    logic            w_cfix;
    logic            w_lo_zero;

    always_comb begin
        w_kind    = c_k_shift;
        w_s       = bus.in_Amt[c_lw-1:0];
        w_cfix    = bus.in_C_flag;
        w_lo_zero = (bus.in_Amt[c_lw-1:0] == '0);
        if (bus.in_Imm_mode) begin
            if (w_lo_zero) begin
                case (bus.in_Shift_type)
                    c_lsl:   w_kind = c_k_pass;
                    c_lsr:   begin w_kind = c_k_zero; w_cfix = bus.in_Val[WIDTH-1]; end
                    c_asr:   begin w_kind = c_k_sign; w_cfix = bus.in_Val[WIDTH-1]; end
                    default: begin w_kind = c_k_rrx;  w_cfix = bus.in_Val[0]; end
                endcase
            end
        end else if (bus.in_Amt == '0) begin
            w_kind = c_k_pass;
        end else begin
            case (bus.in_Shift_type)
                c_lsl: if (bus.in_Amt >= c_width_amt) begin
                    w_kind = c_k_zero;
                    w_cfix = (bus.in_Amt == c_width_amt) ? bus.in_Val[0] : 1'b0;
                end
                c_lsr: if (bus.in_Amt >= c_width_amt) begin
                    w_kind = c_k_zero;
                    w_cfix = (bus.in_Amt == c_width_amt) ? bus.in_Val[WIDTH-1] : 1'b0;
                end
                c_asr: if (bus.in_Amt >= c_width_amt) begin
                    w_kind = c_k_sign;
                    w_cfix = bus.in_Val[WIDTH-1];
                end
                default: if (w_lo_zero) begin
                    w_kind = c_k_pass;
                    w_cfix = bus.in_Val[WIDTH-1];
                end
            endcase
        end
    end

    logic             r_valid;
    logic [WIDTH-1:0] r_op2;
    logic             r_carry;
    logic             w_out_ready;
    logic             w_in_ready;

    logic             w_net_valid;
    logic [WIDTH-1:0] w_net_val;
    logic [2:0]       w_net_kind;
    logic [c_lw-1:0]  w_net_s;
    logic [1:0]       w_net_type;
    logic             w_net_cfix;
    logic             w_net_c;

    assign w_out_ready = !r_valid || bus.in_Ready;

`ifdef SHIFTER_PIPE2_EN
    logic             r_d_valid;
    logic [WIDTH-1:0] r_d_val;
    logic [2:0]       r_d_kind;
    logic [c_lw-1:0]  r_d_s;
    logic [1:0]       r_d_type;
    logic             r_d_cfix;
    logic             r_d_c;

    assign w_in_ready = !in_Rst && (!r_d_valid || w_out_ready);

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            r_d_valid <= 1'b0;
            r_d_val   <= '0;
            r_d_kind  <= c_k_pass;
            r_d_s     <= '0;
            r_d_type  <= 2'b00;
            r_d_cfix  <= 1'b0;
            r_d_c     <= 1'b0;
        end else if (w_in_ready) begin
            r_d_valid <= bus.in_Valid;
            if (bus.in_Valid) begin
                r_d_val  <= bus.in_Val;
                r_d_kind <= w_kind;
                r_d_s    <= w_s;
                r_d_type <= bus.in_Shift_type;
                r_d_cfix <= w_cfix;
                r_d_c    <= bus.in_C_flag;
            end
        end
    end

    assign w_net_valid = r_d_valid;
    assign w_net_val   = r_d_val;
    assign w_net_kind  = r_d_kind;
    assign w_net_s     = r_d_s;
    assign w_net_type  = r_d_type;
    assign w_net_cfix  = r_d_cfix;
    assign w_net_c     = r_d_c;
`else
    assign w_in_ready  = !in_Rst && w_out_ready;
    assign w_net_valid = bus.in_Valid;
    assign w_net_val   = bus.in_Val;
    assign w_net_kind  = w_kind;
    assign w_net_s     = w_s;
    assign w_net_type  = bus.in_Shift_type;
    assign w_net_cfix  = w_cfix;
    assign w_net_c     = bus.in_C_flag;
`endif

    logic [WIDTH-1:0]   w_res;
    logic               w_cy;
    logic [2*WIDTH-1:0] w_rot_dbl;
    logic [c_lw-1:0]    w_neg_s;
    logic [c_lw-1:0]    w_s_m1;

    // In the shift kind s is 1..WIDTH-1, so -s wraps to WIDTH-s.
    always_comb begin
        w_res     = w_net_val;
        w_cy      = w_net_cfix;
        w_rot_dbl = {w_net_val, w_net_val} >> w_net_s;
        w_neg_s   = c_lw'(0) - w_net_s;
        w_s_m1    = w_net_s - c_lw'(1);
        case (w_net_kind)
            c_k_pass: w_res = w_net_val;
            c_k_zero: w_res = '0;
            c_k_sign: w_res = {WIDTH{w_net_val[WIDTH-1]}};
            c_k_rrx:  w_res = {w_net_c, w_net_val[WIDTH-1:1]};
            default: begin
                w_cy = w_net_val[w_s_m1];
                case (w_net_type)
                    c_lsl: begin
                        w_res = w_net_val << w_net_s;
                        w_cy  = w_net_val[w_neg_s];
                    end
                    c_lsr:   w_res = w_net_val >> w_net_s;
                    c_asr:   w_res = $signed(w_net_val) >>> w_net_s;
                    default: w_res = w_rot_dbl[WIDTH-1:0];
                endcase
            end
        endcase
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            r_valid <= 1'b0;
            r_op2   <= '0;
            r_carry <= 1'b0;
        end else if (w_out_ready) begin
            r_valid <= w_net_valid;
            if (w_net_valid) begin
                r_op2   <= w_res;
                r_carry <= w_cy;
            end
        end
    end

    assign bus.out_Ready = w_in_ready;
    assign bus.out_Valid = r_valid;
    assign bus.out_Op2   = r_op2;
    assign bus.out_Carry = r_carry;
endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_shift_pipe
// Brief    : Scoreboard bench driving a 32-bit and an 8-bit shifter in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_shift_pipe;
`ifdef SHIFTER_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic clk;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   rdy_mode = 0;
    logic [64:0] exp32[$];
    logic [64:0] exp8[$];

    barrel_shift_pipe_if #(.WIDTH(32), .AMT_W(8)) ifc ();
    barrel_shift_pipe_if #(.WIDTH(8),  .AMT_W(8)) ifc8 ();

    assign ifc8.in_Valid      = ifc.in_Valid;
    assign ifc8.in_Val        = ifc.in_Val[7:0];
    assign ifc8.in_Amt        = ifc.in_Amt;
    assign ifc8.in_Shift_type = ifc.in_Shift_type;
    assign ifc8.in_Imm_mode   = ifc.in_Imm_mode;
    assign ifc8.in_C_flag     = ifc.in_C_flag;
    assign ifc8.in_Ready      = ifc.in_Ready;

    barrel_shift_pipe #(.WIDTH(32), .AMT_W(8)) u_dut32 (.in_Clk(clk), .in_Rst(rst), .bus(ifc.slave));
    barrel_shift_pipe #(.WIDTH(8),  .AMT_W(8)) u_dut8  (.in_Clk(clk), .in_Rst(rst), .bus(ifc8.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: result bits defined one by one from the shift definitions.
    function automatic logic [64:0] model(input int w, input logic [63:0] val, input int amt,
                                          input logic [1:0] typ, input logic imm, input logic c);
        logic [63:0] r;
        logic        cy;
        int          eff;
        int          m;
        r   = '0;
        cy  = c;
        eff = imm ? (amt % w) : amt;
        if (imm && eff == 0 && typ == ROR) begin
            for (int i = 0; i < w; i++) r[i] = (i == w - 1) ? c : val[i + 1];
            cy = val[0];
            return {cy, r};
        end
        if (imm && eff == 0 && (typ == LSR || typ == ASR)) eff = w;
        if (eff == 0) begin
            for (int i = 0; i < w; i++) r[i] = val[i];
            return {c, r};
        end
        case (typ)
            LSL: begin
                for (int i = 0; i < w; i++) r[i] = (i >= eff) ? val[i - eff] : 1'b0;
                cy = (eff <= w) ? val[w - eff] : 1'b0;
            end
            LSR: begin
                for (int i = 0; i < w; i++) r[i] = (i + eff < w) ? val[i + eff] : 1'b0;
                cy = (eff <= w) ? val[eff - 1] : 1'b0;
            end
            ASR: begin
                for (int i = 0; i < w; i++) r[i] = (i + eff < w) ? val[i + eff] : val[w - 1];
                cy = (eff <= w) ? val[eff - 1] : val[w - 1];
            end
            default: begin
                m = eff % w;
                for (int i = 0; i < w; i++) r[i] = val[(i + m) % w];
                cy = val[(m + w - 1) % w];
            end
        endcase
        return {cy, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] v, input logic [7:0] a, input logic [1:0] t,
                        input logic im, input logic c);
        int guard;
        @(negedge clk);
        ifc.in_Valid      = 1'b1;
        ifc.in_Val        = v;
        ifc.in_Amt        = a;
        ifc.in_Shift_type = t;
        ifc.in_Imm_mode   = im;
        ifc.in_C_flag     = c;
        guard = 0;
        #1;
        while (!ifc.out_Ready) begin
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=stalled required=accept");
                return;
            end
            @(negedge clk);
            #1;
        end
        exp32.push_back(model(32, {32'd0, v}, int'(a), t, im, c));
        exp8.push_back(model(8, {32'd0, v}, int'(a), t, im, c));
    endtask

    task automatic idle();
        @(negedge clk);
        ifc.in_Valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        rdy_mode = 0;
        while ((exp32.size() != 0 || exp8.size() != 0) && g < 200) begin
            @(negedge clk);
            #2;
            g++;
        end
        if (exp32.size() != 0 || exp8.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0", exp32.size(), exp8.size());
        end
    endtask

    initial begin
        ifc.in_Ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       ifc.in_Ready = 1'b1;
                2:       ifc.in_Ready = 1'b0;
                default: ifc.in_Ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pop on every delivery, and check held outputs under backpressure.
    initial begin
        logic        hold;
        logic [31:0] hop2;
        logic        hcy;
        logic [64:0] e;
        hold = 1'b0;
        hop2 = '0;
        hcy  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp32.delete();
                exp8.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checks++;
                    if (ifc.out_Valid !== 1'b1 || ifc.out_Op2 !== hop2 || ifc.out_Carry !== hcy) begin
                        failures++;
                        $display("FAIL hold_stable actual=%b/%h/%b required=1/%h/%b",
                                 ifc.out_Valid, ifc.out_Op2, ifc.out_Carry, hop2, hcy);
                    end
                end
                hold = ifc.out_Valid && !ifc.in_Ready;
                hop2 = ifc.out_Op2;
                hcy  = ifc.out_Carry;
                if (ifc.out_Valid && ifc.in_Ready) begin
                    checks++;
                    if (exp32.size() == 0) begin
                        failures++;
                        $display("FAIL out32_unexpected actual=%h required=none", ifc.out_Op2);
                    end else begin
                        e = exp32.pop_front();
                        if ({ifc.out_Carry, 32'd0, ifc.out_Op2} !== e) begin
                            failures++;
                            $display("FAIL out32 actual=%b/%h required=%b/%h",
                                     ifc.out_Carry, ifc.out_Op2, e[64], e[31:0]);
                        end
                    end
                end
                if (ifc8.out_Valid && ifc8.in_Ready) begin
                    checks++;
                    if (exp8.size() == 0) begin
                        failures++;
                        $display("FAIL out8_unexpected actual=%h required=none", ifc8.out_Op2);
                    end else begin
                        e = exp8.pop_front();
                        if ({ifc8.out_Carry, 56'd0, ifc8.out_Op2} !== e) begin
                            failures++;
                            $display("FAIL out8 actual=%b/%h required=%b/%h",
                                     ifc8.out_Carry, ifc8.out_Op2, e[64], e[7:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int k;
        int specials[7] = '{0, 7, 8, 9, 31, 32, 33};
        logic [7:0] a;
        rst               = 1'b1;
        ifc.in_Valid      = 1'b1;
        ifc.in_Val        = 32'hDEAD_BEEF;
        ifc.in_Amt        = 8'd3;
        ifc.in_Shift_type = LSL;
        ifc.in_Imm_mode   = 1'b0;
        ifc.in_C_flag     = 1'b1;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_out_valid", {63'd0, ifc.out_Valid}, 64'd0);
        chk("rst_op2",       {32'd0, ifc.out_Op2},   64'd0);
        chk("rst_carry",     {63'd0, ifc.out_Carry}, 64'd0);
        chk("rst_out_ready", {63'd0, ifc.out_Ready}, 64'd0);
        @(negedge clk);
        rst          = 1'b0;
        ifc.in_Valid = 1'b0;

        // Latency from accept to out_Valid
        send(32'd2, 8'd1, LSL, 1'b1, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            ifc.in_Valid = 1'b0;
            #1;
            k++;
        end while (!ifc.out_Valid && k < 8);
        chk("latency", 64'(k), 64'(LAT));
        drain();

        send(32'd200,        8'd0,   ROR, 1'b1, 1'b1);
        send(32'hFFB3_B4C0,  8'd0,   ASR, 1'b1, 1'b0);
        send(32'h8000_0000,  8'd32,  LSR, 1'b0, 1'b0);
        send(32'h8000_0000,  8'd33,  LSR, 1'b0, 1'b1);
        send(32'h0000_00C8,  8'd36,  ROR, 1'b0, 1'b0);
        send(32'h0000_0090,  8'd200, ASR, 1'b0, 1'b0);
        send(32'h0000_0001,  8'd32,  LSL, 1'b0, 1'b0);
        send(32'h0000_0001,  8'd33,  LSL, 1'b0, 1'b1);
        send(32'h0000_0005,  8'd0,   ROR, 1'b0, 1'b1);
        send(32'h8000_0001,  8'd64,  ROR, 1'b0, 1'b0);
        send(32'h0000_0081,  8'd0,   LSR, 1'b1, 1'b0);
        idle();
        drain();

        // Backpressure: fill the pipe while downstream stalls
        rdy_mode = 2;
        fork
            begin
                send(32'h1111_0001, 8'd4, LSL, 1'b1, 1'b0);
                send(32'h2222_0002, 8'd5, LSR, 1'b0, 1'b1);
                send(32'h3333_0003, 8'd6, ROR, 1'b0, 1'b0);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                #2;
                chk("full_out_ready", {63'd0, ifc.out_Ready}, 64'd0);
                chk("full_out_valid", {63'd0, ifc.out_Valid}, 64'd1);
                rdy_mode = 0;
            end
        join
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 8'($urandom_range(0, 7));
                1:       a = 8'($urandom_range(0, 40));
                2:       a = 8'($urandom_range(0, 255));
                default: a = 8'(specials[$urandom_range(0, 6)]);
            endcase
            send($urandom, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        drain();

        // Reset with an operation in flight
        rdy_mode = 2;
        send(32'h1234_5678, 8'd4, LSL, 1'b1, 1'b1);
        @(negedge clk);
        ifc.in_Valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        #2;
        chk("flush_out_valid", {63'd0, ifc.out_Valid}, 64'd0);
        chk("flush_op2",       {32'd0, ifc.out_Op2},   64'd0);
        chk("flush_carry",     {63'd0, ifc.out_Carry}, 64'd0);
        chk("flush_out_ready", {63'd0, ifc.out_Ready}, 64'd0);
        chk("flush_op2_w8",    {56'd0, ifc8.out_Op2},  64'd0);
        rst      = 1'b0;
        rdy_mode = 0;
        repeat (8) @(negedge clk);
        #2;
        chk("flush_idle_valid", {63'd0, ifc.out_Valid}, 64'd0);
        chk("queue32_empty", 64'(exp32.size()), 64'd0);
        chk("queue8_empty",  64'(exp8.size()),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter AMT_W, default 8, the shift-amount width; AMT_W SHALL be at least log2(WIDTH)+1.
REQ-003 in_Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 in_Rst  input  1  reset, synchronous and active-high.
REQ-005 in_Valid  input  1  upstream presents an operation.
REQ-006 out_Ready  output  1  block accepts the operation this cycle.
REQ-007 in_Val  input  WIDTH  operand to shift.
REQ-008 in_Amt  input  AMT_W  shift amount.
REQ-009 in_Shift_type  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 in_Imm_mode  input  1  amount encoding: 1 = immediate, using only in_Amt[log2(WIDTH)-1:0]; 0 = register, using all of in_Amt.
REQ-011 in_C_flag  input  1  current carry flag.
REQ-012 out_Valid  output  1  a result is presented.
REQ-013 in_Ready  input  1  downstream accepts the result.
REQ-014 out_Op2  output  WIDTH  shifted operand.
REQ-015 out_Carry  output  1  shifter carry-out.

Function
REQ-016 SHALL accept an operation on a rising edge where in_Valid=1 and out_Ready=1, capturing all in_* operands on that edge.
REQ-017 SHALL deliver a result on a rising edge where out_Valid=1 and in_Ready=1.
REQ-018 Each pipeline stage SHALL hold a valid bit and be ready when it is empty or when its downstream is ready; out_Ready equals stage-1 ready.
REQ-019 While out_Valid=1 and in_Ready=0, out_Op2 and out_Carry SHALL hold stable; no operation is lost, duplicated or reordered.
REQ-020 Accept and deliver in the same cycle SHALL sustain a throughput of one operation per clock.
REQ-021 Immediate mode, n = amount: LSL n=0 -> Op2=Val, Carry=C; LSL n>0 -> Val<<n, Carry=Val[WIDTH-n].
REQ-022 Immediate LSR: n=0 means shift by WIDTH -> Op2=0, Carry=Val[WIDTH-1]; n>0 -> Val>>n, Carry=Val[n-1].
REQ-023 Immediate ASR: n=0 -> Op2=all bits Val[WIDTH-1], Carry=Val[WIDTH-1]; n>0 -> arithmetic shift, Carry=Val[n-1].
REQ-024 Immediate ROR: n=0 is RRX -> Op2={C,Val[WIDTH-1:1]}, Carry=Val[0]; n>0 -> rotate right by n, Carry=Val[n-1].
REQ-025 Register mode, n=0: all types -> Op2=Val, Carry=C.
REQ-026 Register LSL/LSR with 0<n<WIDTH SHALL behave as immediate mode with n>0.
REQ-027 Register LSL: n=WIDTH -> 0, Carry=Val[0]; n>WIDTH -> 0, Carry=0.
REQ-028 Register LSR: n=WIDTH -> 0, Carry=Val[WIDTH-1]; n>WIDTH -> 0, Carry=0.
REQ-029 Register ASR: n>=WIDTH -> sign fill, Carry=Val[WIDTH-1].
REQ-030 Register ROR: m = n mod WIDTH; m=0 -> Op2=Val, Carry=Val[WIDTH-1]; otherwise rotate by m, Carry=Val[m-1].
REQ-031 Latency SHALL be 1 cycle from the accept edge to out_Valid=1, with the macro in REQ-035 undefined.

Reset
REQ-032 While in_Rst=1, out_Ready SHALL be 0 and in_Valid SHALL be ignored.
REQ-033 On an edge with in_Rst=1: out_Valid=0, out_Op2=0, out_Carry=0, and all internal stage valid bits clear, discarding in-flight operations.
REQ-034 The first accept after reset SHALL occur no earlier than the first edge with in_Rst=0.

Configuration
REQ-035 Macro SHIFTER_PIPE2_EN: when defined, SHALL insert a register stage between amount decode and the shift network, giving latency 2 and still one operation per clock; when undefined, the design SHALL be single-stage with latency 1. Function and handshake rules are identical in both builds.

Verification
REQ-036 WIDTH=32, imm LSL Val=2 n=1 C=0 -> Op2=4, Carry=0, out_Valid one cycle after accept (two with SHIFTER_PIPE2_EN).
REQ-037 Imm ROR Val=200 n=0 C=1 -> Op2=0x80000064, Carry=0; imm ASR Val=0xFFB3B4C0 n=0 -> Op2=0xFFFFFFFF, Carry=1.
REQ-038 Reg LSR Val=0x80000000 n=32 -> 0, Carry=1; n=33 -> 0, Carry=0; reg ROR Val=0xC8 n=36 -> 0x8000000C, Carry=1.
REQ-039 Three back-to-back accepts with in_Ready=0 for 3 cycles -> out_Ready drops when full, outputs stable, all three results delivered in order.
REQ-040 Assert in_Rst with an operation in flight -> next edge out_Valid=0, out_Op2=0, out_Carry=0; nothing delivered afterwards.
REQ-041 WIDTH=8, reg ASR Val=0x90 n=200 -> Op2=0xFF, Carry=1.
